// File: rtl/register_writeback_arbiter.sv
// Register file write-port controller: load writeback beats ALU writeback, losing ALU
// results queue in a small FIFO, and a busy scoreboard raises decode hazard stalls.
module register_writeback_arbiter #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          alu_wb_valid,
    output logic                          alu_wb_ready,
    input  logic [4:0]                    alu_wb_rd,
    input  logic [31:0]                   alu_wb_data,
    input  logic                          mem_wb_valid,
    input  logic [4:0]                    mem_wb_rd,
    input  logic [31:0]                   mem_wb_data,
    input  logic                          load_issue,
    input  logic [4:0]                    load_issue_rd,
    input  logic [4:0]                    regA_address,
    input  logic [4:0]                    regB_address,
    output logic                          hazard_stall,
    output logic                          register_write_en,
    output logic [4:0]                    rd_address,
    output logic [31:0]                   register_write_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    logic [4:0]            fifo_rd   [FIFO_DEPTH];
    logic [31:0]           fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_vld;
    logic [31:0]           busy;
    logic [31:0]           busy_next;

    logic alu_live;
    logic mem_live;
    logic fifo_empty;
    logic pop;
    logic push;
    logic alu_direct;
    logic hit_a;
    logic hit_b;

    // Handshake: an ALU result transfers on any rising edge where alu_wb_valid and
    // alu_wb_ready are both high; ready depends only on registered occupancy.
    assign alu_wb_ready = rst && (fifo_count < DEPTH_C);
    assign alu_live     = alu_wb_valid && alu_wb_ready && (alu_wb_rd != 5'd0);
    assign mem_live     = mem_wb_valid && (mem_wb_rd != 5'd0);
    assign fifo_empty   = (fifo_count == '0);
    assign pop          = !mem_live && !fifo_empty;
    assign alu_direct   = !mem_live && fifo_empty && alu_live;
    assign push         = alu_live && !alu_direct;

    always_comb begin
        busy_next = busy;
        if (mem_wb_valid) begin
            busy_next[mem_wb_rd] = 1'b0;
        end
        // A same-cycle issue to the returning register must leave it busy.
        if (load_issue && (load_issue_rd != 5'd0)) begin
            busy_next[load_issue_rd] = 1'b1;
        end
    end

    always_comb begin
        hit_a = busy[regA_address];
        hit_b = busy[regB_address];
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (fifo_vld[i] && (fifo_rd[i] == regA_address)) begin
                hit_a = 1'b1;
            end
            if (fifo_vld[i] && (fifo_rd[i] == regB_address)) begin
                hit_b = 1'b1;
            end
        end
        hazard_stall = rst && (((regA_address != 5'd0) && hit_a) ||
                               ((regB_address != 5'd0) && hit_b));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            register_write_en   <= 1'b0;
            rd_address          <= 5'd0;
            register_write_data <= 32'd0;
            head                <= '0;
            tail                <= '0;
            fifo_count          <= '0;
            fifo_vld            <= '0;
            busy                <= '0;
        end else begin
            if (mem_live) begin
                register_write_en   <= 1'b1;
                rd_address          <= mem_wb_rd;
                register_write_data <= mem_wb_data;
            end else if (!fifo_empty) begin
                register_write_en   <= 1'b1;
                rd_address          <= fifo_rd[head];
                register_write_data <= fifo_data[head];
            end else if (alu_live) begin
                register_write_en   <= 1'b1;
                rd_address          <= alu_wb_rd;
                register_write_data <= alu_wb_data;
            end else begin
                register_write_en   <= 1'b0;
            end

            // Push never happens when full, so head and tail differ whenever both move.
            if (pop) begin
                fifo_vld[head] <= 1'b0;
                head           <= head + 1'b1;
            end
            if (push) begin
                fifo_vld[tail] <= 1'b1;
                tail           <= tail + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase

            busy <= busy_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[tail]   <= alu_wb_rd;
            fifo_data[tail] <= alu_wb_data;
        end
    end

endmodule

// File: tb/tb_register_writeback_arbiter.sv
// Bench for register_writeback_arbiter: queue-based reference model checked every cycle,
// ALU write-order scoreboard, and directed vectors with literal expectations.
module tb_register_writeback_arbiter;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        alu_wb_valid = 1'b0;
  logic        alu_wb_ready;
  logic [4:0]  alu_wb_rd = 5'd0;
  logic [31:0] alu_wb_data = 32'd0;
  logic        mem_wb_valid = 1'b0;
  logic [4:0]  mem_wb_rd = 5'd0;
  logic [31:0] mem_wb_data = 32'd0;
  logic        load_issue = 1'b0;
  logic [4:0]  load_issue_rd = 5'd0;
  logic [4:0]  regA_address = 5'd0;
  logic [4:0]  regB_address = 5'd0;
  logic        hazard_stall;
  logic        register_write_en;
  logic [4:0]  rd_address;
  logic [31:0] register_write_data;
  logic [1:0]  fifo_count;

  register_writeback_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_wb_valid(alu_wb_valid), .alu_wb_ready(alu_wb_ready),
    .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
    .mem_wb_valid(mem_wb_valid), .mem_wb_rd(mem_wb_rd), .mem_wb_data(mem_wb_data),
    .load_issue(load_issue), .load_issue_rd(load_issue_rd),
    .regA_address(regA_address), .regB_address(regB_address),
    .hazard_stall(hazard_stall), .register_write_en(register_write_en),
    .rd_address(rd_address), .register_write_data(register_write_data),
    .fifo_count(fifo_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // reference model: pending ALU writes as a queue, busy as a bit vector
  logic [36:0] mq[$];
  logic [31:0] busy_m = 32'd0;
  logic        m_wen = 1'b0;
  logic [4:0]  m_rd = 5'd0;
  logic [31:0] m_data = 32'd0;

  function automatic bit m_hz(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    if (busy_m[a]) return 1'b1;
    foreach (mq[i]) if (mq[i][36:32] == a) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) begin : model
    bit acc;
    if (!rst) begin
      mq.delete();
      busy_m = 32'd0;
      m_wen = 1'b0;
      m_rd = 5'd0;
      m_data = 32'd0;
    end else begin
      acc = alu_wb_valid && (mq.size() < DEPTH) && (alu_wb_rd != 5'd0);
      if (mem_wb_valid && mem_wb_rd != 5'd0) begin
        m_wen = 1'b1; m_rd = mem_wb_rd; m_data = mem_wb_data;
        if (acc) mq.push_back({alu_wb_rd, alu_wb_data});
      end else if (mq.size() > 0) begin
        {m_rd, m_data} = mq.pop_front();
        m_wen = 1'b1;
        if (acc) mq.push_back({alu_wb_rd, alu_wb_data});
      end else if (acc) begin
        m_wen = 1'b1; m_rd = alu_wb_rd; m_data = alu_wb_data;
      end else begin
        m_wen = 1'b0;
      end
      if (mem_wb_valid) busy_m[mem_wb_rd] = 1'b0;
      if (load_issue && load_issue_rd != 5'd0) busy_m[load_issue_rd] = 1'b1;
    end
  end

  // register file fed by the DUT write port
  logic [31:0] rf [32] = '{default: 32'd0};
  always @(posedge clk) if (register_write_en && rd_address != 5'd0) rf[rd_address] <= register_write_data;

  // scoreboard of accepted ALU writes, in handshake order
  logic [36:0] exp_q[$];
  always @(posedge clk) begin
    if (!rst) exp_q.delete();
    else if (alu_wb_valid && alu_wb_ready && alu_wb_rd != 5'd0) exp_q.push_back({alu_wb_rd, alu_wb_data});
  end

  function automatic bit is_alu_rd(input logic [4:0] r);
    return (r != 5'd0) && (r != 5'd4) && (r != 5'd7) && (r < 5'd16);
  endfunction

  // per-cycle compare, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("wen", register_write_en, m_wen);
      chk("rd_address", rd_address, m_rd);
      chk("write_data", register_write_data, m_data);
      chk("fifo_count", fifo_count, mq.size());
      chk("alu_ready", alu_wb_ready, rst && (mq.size() < DEPTH));
      chk("hazard", hazard_stall, rst && (m_hz(regA_address) || m_hz(regB_address)));
      if (register_write_en && is_alu_rd(rd_address)) begin
        if (exp_q.size() == 0) chk("alu_extra_write", {rd_address, register_write_data}, 37'd0);
        else chk("alu_order", {rd_address, register_write_data}, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    alu_wb_valid = 1'b0;
    mem_wb_valid = 1'b0;
    load_issue = 1'b0;
  endtask

  initial begin
    int idx;
    bit acc;

    // reset with everything asserted
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd5; alu_wb_data = 32'h1;
    mem_wb_valid = 1'b1; mem_wb_rd = 5'd4; mem_wb_data = 32'h2;
    load_issue = 1'b1; load_issue_rd = 5'd7;
    regA_address = 5'd7; regB_address = 5'd4;
    step();
    cmp_en = 1'b1;
    step();
    chk("rst_wen", register_write_en, 1'b0);
    chk("rst_count", fifo_count, 2'd0);
    chk("rst_ready", alu_wb_ready, 1'b0);
    chk("rst_hazard", hazard_stall, 1'b0);
    clear_inputs();
    regA_address = 5'd0; regB_address = 5'd0;
    rst = 1'b1;
    #1;
    chk("post_rst_ready", alu_wb_ready, 1'b1);

    // ALU only
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd5; alu_wb_data = 32'd25;
    step();
    clear_inputs();
    chk("alu_wen", register_write_en, 1'b1);
    chk("alu_rd", rd_address, 5'd5);
    chk("alu_data", register_write_data, 32'd25);
    step();
    chk("alu_rf_x5", rf[5], 32'd25);
    chk("alu_idle_wen", register_write_en, 1'b0);

    // contention: load wins, ALU waits one cycle in the FIFO
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd3; alu_wb_data = 32'h11;
    mem_wb_valid = 1'b1; mem_wb_rd = 5'd4; mem_wb_data = 32'h22;
    step();
    clear_inputs();
    chk("cont_rd_load", rd_address, 5'd4);
    chk("cont_data_load", register_write_data, 32'h22);
    chk("cont_count1", fifo_count, 2'd1);
    regB_address = 5'd3;
    #1;
    chk("cont_fifo_hazard", hazard_stall, 1'b1);
    step();
    chk("cont_rd_alu", rd_address, 5'd3);
    chk("cont_data_alu", register_write_data, 32'h11);
    chk("cont_count0", fifo_count, 2'd0);
    chk("cont_hazard_gone", hazard_stall, 1'b0);
    step();
    chk("cont_rf_x3", rf[3], 32'h11);
    chk("cont_rf_x4", rf[4], 32'h22);
    regB_address = 5'd0;

    // backpressure: ALU every cycle, loads for the first 4 cycles
    idx = 0;
    for (int c = 0; c < 14; c++) begin
      mem_wb_valid = (c < 4); mem_wb_rd = 5'(20 + c); mem_wb_data = 32'h1000 + 32'(c);
      alu_wb_valid = (idx < 6); alu_wb_rd = 5'(8 + idx); alu_wb_data = 32'hA0 + 32'(idx);
      #1;
      if (c == 2) begin
        chk("bp_ready_low", alu_wb_ready, 1'b0);
        chk("bp_count_full", fifo_count, 2'd2);
      end
      acc = alu_wb_valid && alu_wb_ready;
      step();
      if (acc) idx++;
    end
    clear_inputs();
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) step();
    chk("bp_drained", exp_q.size(), 0);
    chk("bp_all_sent", idx, 6);
    chk("bp_rf_x13", rf[13], 32'hA5);
    chk("bp_rf_x23", rf[23], 32'h1003);

    // scoreboard hazard
    load_issue = 1'b1; load_issue_rd = 5'd7;
    step();
    clear_inputs();
    regA_address = 5'd7;
    #1;
    chk("sb_hazard_set", hazard_stall, 1'b1);
    step(); step();
    chk("sb_hazard_held", hazard_stall, 1'b1);
    mem_wb_valid = 1'b1; mem_wb_rd = 5'd7; mem_wb_data = 32'h77;
    #1;
    chk("sb_hazard_return_cycle", hazard_stall, 1'b1);
    step();
    clear_inputs();
    #1;
    chk("sb_hazard_cleared", hazard_stall, 1'b0);
    chk("sb_load_data", register_write_data, 32'h77);
    load_issue = 1'b1; load_issue_rd = 5'd7;
    mem_wb_valid = 1'b1; mem_wb_rd = 5'd7; mem_wb_data = 32'h78;
    step();
    clear_inputs();
    chk("sb_set_wins", hazard_stall, 1'b1);
    mem_wb_valid = 1'b1; mem_wb_rd = 5'd7; mem_wb_data = 32'h79;
    step();
    clear_inputs();
    chk("sb_final_clear", hazard_stall, 1'b0);
    regA_address = 5'd0;
    step();

    // rd = 0 on both sources
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd0; alu_wb_data = 32'hFF;
    mem_wb_valid = 1'b1; mem_wb_rd = 5'd0; mem_wb_data = 32'hEE;
    #1;
    chk("rd0_ready", alu_wb_ready, 1'b1);
    step();
    clear_inputs();
    chk("rd0_no_wen", register_write_en, 1'b0);
    chk("rd0_count", fifo_count, 2'd0);
    step();
    chk("rd0_still_no_wen", register_write_en, 1'b0);
    chk("rd0_rf_x0", rf[0], 32'd0);

    // reset mid-operation discards FIFO content
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd5; alu_wb_data = 32'h55;
    mem_wb_valid = 1'b1; mem_wb_rd = 5'd4; mem_wb_data = 32'h44;
    step();
    clear_inputs();
    chk("mid_count1", fifo_count, 2'd1);
    rst = 1'b0;
    step();
    chk("mid_rst_wen", register_write_en, 1'b0);
    chk("mid_rst_count", fifo_count, 2'd0);
    chk("mid_rst_rd", rd_address, 5'd0);
    rst = 1'b1;
    step();
    chk("mid_no_stale_write", register_write_en, 1'b0);
    step();
    chk("mid_rf_x5_kept", rf[5], 32'd25);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/register_writeback_arbiter.md
# register_writeback_arbiter

Controller for the register file's single write port. It arbitrates between ALU writeback and load (memory) writeback, and buffers ALU results that lose arbitration in a small FIFO. It keeps a per-register busy scoreboard for outstanding loads and raises a hazard stall to decode when a source register has a pending write. It sits between the execute/memory stages and the register file write inputs.

## Interface
- FIFO_DEPTH, 2, ALU overflow FIFO entries; power of two, >= 2
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-low
- alu_wb_valid  in  1  ALU result offered
- alu_wb_ready  out  1  ALU result accepted this cycle when high with valid
- alu_wb_rd  in  5  ALU destination register
- alu_wb_data  in  32  ALU result
- mem_wb_valid  in  1  load data returning; always accepted (no ready)
- mem_wb_rd  in  5  load destination register
- mem_wb_data  in  32  load data
- load_issue  in  1  a load is issued to memory this cycle
- load_issue_rd  in  5  destination of issued load
- regA_address, regB_address  in  5 each  decode source registers
- hazard_stall  out  1  decode must stall
- register_write_en  out  1  register file write enable (registered)
- rd_address  out  5  register file write address (registered)
- register_write_data  out  32  register file write data (registered)
- fifo_count  out  $clog2(FIFO_DEPTH)+1  ALU FIFO occupancy (registered)

## Operation
- The clock and reset are fixed: one clock `clk`; reset `rst` is synchronous and active-low.
- Reset (rst=0 sampled at an edge): register_write_en=0, rd_address=0, register_write_data=0, FIFO empty (fifo_count=0), all busy bits 0. While rst=0, alu_wb_ready=0 and hazard_stall=0.
- alu_wb_ready = rst && (fifo_count < FIFO_DEPTH). It depends only on registered count, never on mem_wb_valid.
- Write sources with rd==0 are discarded. ALU rd==0 is still handshaken (consumed) but never enqueued or issued. Load rd==0 is ignored.
- Write-port select each cycle, in priority order:
  1. mem_wb_valid (rd!=0)
  2. FIFO head
  3. incoming accepted ALU result, only when the FIFO is empty
- The selected write is loaded into the output registers. If nothing is selected, register_write_en goes to 0 and rd_address/register_write_data hold their values.
- An accepted ALU result that is not selected is pushed to the FIFO tail in the same cycle. Push and pop in the same cycle leave the count unchanged. FIFO order is strict FIFO, and the pointers wrap modulo FIFO_DEPTH.
- Scoreboard busy[31:0]:
  - load_issue with load_issue_rd!=0 sets busy[load_issue_rd].
  - mem_wb_valid clears busy[mem_wb_rd].
  - If set and clear target the same register in the same cycle, set wins.
  - A load returning to a non-busy register is still written; busy is unchanged.
- hazard_stall (combinational) is high if either of the following holds for regA_address or regB_address (nonzero only):
  - busy[reg] is set;
  - any valid FIFO entry targets reg.
- The output write stage is not a hazard: the register file forwards same-cycle writes to its read ports.

## Timing
- ALU, FIFO empty, no load: accepted at edge N, so register_write_en=1 during cycle N..N+1, and the register file commits at edge N+1.
- Load return: same one-cycle latency as ALU, and it always wins.
- Contention (ALU and load in the same cycle): load is written at edge N+1; ALU goes to the FIFO at edge N and is written at edge N+2 if no further load arrives.
- Continuous loads starve the FIFO. This is allowed; ALU is backpressured through alu_wb_ready.
- FIFO full: alu_wb_ready=0 in that cycle; ALU data must be held by the upstream stage.
- Synchronous reset mid-operation discards FIFO contents and the pending write at the next edge; no partial write occurs.

## Test plan
- Reset: hold rst=0 for 2 edges with all valids high -> register_write_en=0, fifo_count=0, alu_wb_ready=0, hazard_stall=0.
- ALU only: alu rd=5, data=25 -> next cycle register_write_en=1, rd_address=5, data=25; regfile reads 25 from x5 afterwards.
- Contention: same cycle ALU (rd=3, 0x11) and load (rd=4, 0x22) -> write x4=0x22, then x3=0x11 on the following cycle; fifo_count goes 1 then 0.
- Backpressure: ALU valid every cycle plus load valid for 4 cycles, DEPTH=2 -> alu_wb_ready drops after 2 enqueues; all ALU values are written in order, with none lost or duplicated.
- Scoreboard: load_issue rd=7, then regA_address=7 -> hazard_stall=1 until the cycle after mem_wb_valid rd=7. Simultaneous load_issue rd=7 and mem_wb rd=7 -> busy stays set.
- rd=0: ALU rd=0 (data 0xFF) and load rd=0 -> no register_write_en pulse, and x0 reads 0.
